move_history: RTL and testbench
===============================

# move_history

Move-history stack directly upstream of `board_updater`. It accepts each committed move from the game controller and forwards it to `board_updater` as a forward update. It also stores a compressed record of every move. On an undo request it pops the most recent record and replays it to `board_updater` with `undo` asserted.

## Interface
- `DEPTH`, 64 — number of stored move records; must be a power of two, at least 2.
- `clk` in 1 — system clock; all state changes on the rising edge.
- `clear_n` in 1 — asynchronous, active-low reset.
- `push_valid` in 1 — a committed move is presented on the `push_*` fields.
- `push_ready` out 1 — high when the block can accept a push this cycle.
- `push_color_type` in 1 — side that moved; 1 is white, 0 is black.
- `push_initialPosition` in 64 — one-hot source square.
- `push_movedPosition` in 64 — one-hot destination square.
- `push_movingPiece` in 6 — one-hot piece code: pawn, rook, knight, bishop, queen, king = bits 0..5.
- `push_capturedPiece` in 6 — one-hot piece code, same encoding as `push_movingPiece`; 0 means no capture.
- `push_castling` in 2 — 00 none, 01 queen side, 10 king side.
- `push_enpassant` in 5 — same encoding as `board_updater`.
- `undo_req` in 1 — level request to pop one move; held until `undo_ack`.
- `undo_ack` out 1 — one-cycle pulse that completes an undo request.
- `undo_err` out 1 — qualifies `undo_ack`: the pop was refused because the stack is empty.
- `out_valid` out 1 — drives `board_updater.enable`; one-cycle pulse.
- `out_undo` out 1 — drives `board_updater.undo`.
- `out_color_type`, `out_initialPosition`, `out_movedPosition`, `out_movingPiece`, `out_capturedPiece`, `out_castling`, `out_enpassant` out 1/64/64/6/6/2/5 — move fields to `board_updater`.
- `count` out $clog2(DEPTH+1) — number of stored records.
- `empty`, `full` out 1 — stack status flags.
- `bad_onehot` out 1 — sticky: a pushed position field was not exactly one-hot.

## Operation
- Each record is 32 bits: from-index 6, to-index 6, moving 6, captured 6, castling 2, enpassant 5, color 1.
- Positions are compressed to 6-bit indices on push and expanded with `1 << idx` on output.
- A position field that is not one-hot is encoded as its lowest set bit, or 0 if it is all-zero. Either case sets `bad_onehot`.
- FSM states:
  - `IDLE`: `push_ready = !full`.
    - A push handshake writes `mem[top]`, increments `top` and `count`, and registers the move for a forward emit. Next state `IDLE`.
    - Else, `undo_req` with `empty` high pulses `undo_ack` and `undo_err` the next cycle. Next state `IDLE`.
    - Else, `undo_req` with the stack non-empty decrements `top` and `count` and issues a synchronous read of `mem[top-1]`. Next state `POP`.
  - `POP`: `push_ready = 0`. Read data is captured. Next state `EMIT`.
  - `EMIT`: `out_valid = 1`, `out_undo = 1`, `undo_ack = 1`, `undo_err = 0`; the output fields carry the popped record. Next state `IDLE`.
- A push and an undo in the same `IDLE` cycle: the push wins. `undo_req` stays pending and is served afterwards, so it pops the just-pushed move.
- `top` is modulo DEPTH.
- `full` = (`count == DEPTH`); `empty` = (`count == 0`).

## Timing
- Reset values while `clear_n` is low:
  - all `out_*` = 0;
  - `undo_ack`, `undo_err` = 0;
  - `count` = 0, `empty` = 1, `full` = 0;
  - `bad_onehot` = 0;
  - `push_ready` = 1;
  - state = `IDLE`, `top` = 0.
- Forward latency: `out_valid` goes high 1 cycle after the push handshake, with `out_undo = 0`.
- Undo latency: `out_valid`, `out_undo` and `undo_ack` go high 2 cycles after `undo_req` is sampled in `IDLE` on a non-empty stack.
- Empty-undo response: `undo_ack` and `undo_err` go high 1 cycle after sampling.
- Throughput: back-to-back pushes are accepted every cycle, for at most DEPTH pushes in a row.
- Reset in `POP` or `EMIT` aborts the pop. No `out_valid` is produced and the stack is emptied.

## Configuration
- `MOVE_HISTORY_OVERWRITE_EN` defined: `push_ready` ignores `full`.
  - A push when full overwrites the oldest record; the buffer is circular with a `base` pointer.
  - `count` stays at DEPTH and `full` stays high.
- Not defined: a push is refused while `full` (`push_ready = 0`). Undo depth is strictly the last DEPTH moves.

## Structure
- Shared package `chess_pkg` holds:
  - piece one-hot constants (`PIECE_PAWN` .. `PIECE_KING`);
  - castling and enpassant codes;
  - the 32-bit `move_rec_t` record layout and its field offsets.
- Sub-module `onehot64_to_index` produces a 6-bit index plus a `valid_onehot` flag. It is instantiated twice, once for the source square and once for the destination square.

## Test plan
- Push 1: from square 49, to square 56, pawn capturing rook, white. Next cycle: `out_valid = 1`, `out_undo = 0`, `out_initialPosition = 1 << 49`, `out_movedPosition = 1 << 56`; `count = 1`.
- After the previous push, raise `undo_req`. After 2 cycles: `out_valid = 1`, `out_undo = 1`, the same fields, `undo_ack = 1`, `count = 0`, `empty = 1`.
- `undo_req` on an empty stack just after reset: one cycle later `undo_ack = 1` and `undo_err = 1`; `out_valid` stays 0.
- Push DEPTH+1 moves back to back. Without the macro, `push_ready = 0` once `count = 64`. With the macro, the 65th push is accepted; 64 undos then return moves 65..2 in LIFO order.
- Raise `push_valid` and `undo_req` in the same cycle: the push is forwarded first, then the undo replays that same move with `out_undo = 1`.
- Push with `push_initialPosition = 0x3` (two bits set): `bad_onehot = 1` and stays 1; the stored from-index is 0.

Source files
------------

// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared chess move encodings and the 32-bit move-history record layout
package chess_pkg;

    localparam logic [5:0] PIECE_NONE   = 6'b000000;
    localparam logic [5:0] PIECE_PAWN   = 6'b000001;
    localparam logic [5:0] PIECE_ROOK   = 6'b000010;
    localparam logic [5:0] PIECE_KNIGHT = 6'b000100;
    localparam logic [5:0] PIECE_BISHOP = 6'b001000;
    localparam logic [5:0] PIECE_QUEEN  = 6'b010000;
    localparam logic [5:0] PIECE_KING   = 6'b100000;

    localparam logic [1:0] CASTLE_NONE  = 2'b00;
    localparam logic [1:0] CASTLE_QUEEN = 2'b01;
    localparam logic [1:0] CASTLE_KING  = 2'b10;

    localparam logic [4:0] EP_NONE = 5'd0;

    localparam int REC_COLOR_LSB    = 0;
    localparam int REC_EP_LSB       = 1;
    localparam int REC_CASTLE_LSB   = 6;
    localparam int REC_CAPTURED_LSB = 8;
    localparam int REC_MOVING_LSB   = 14;
    localparam int REC_TO_LSB       = 20;
    localparam int REC_FROM_LSB     = 26;

    typedef struct packed {
        logic [5:0] from_idx;
        logic [5:0] to_idx;
        logic [5:0] moving;
        logic [5:0] captured;
        logic [1:0] castling;
        logic [4:0] enpassant;
        logic       color;
    } move_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_EMIT = 2'd2
    } hist_state_t;

    function automatic logic [63:0] idx_to_onehot(input logic [5:0] idx);
        return 64'd1 << idx;
    endfunction

endpackage

// File: rtl/onehot64_to_index.sv
// rtl/onehot64_to_index.sv - 64-bit square mask to 6-bit index, lowest set bit wins
module onehot64_to_index (
    input  logic [63:0] i_vec,
    output logic [5:0]  o_index,
    output logic        o_valid_onehot
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_index = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = 6'(i);
            end
        end
    end

    assign o_valid_onehot = (i_vec != 64'd0) && ((i_vec & (i_vec - 64'd1)) == 64'd0);

endmodule

// File: rtl/move_history.sv
// rtl/move_history.sv - move-history LIFO feeding board_updater; MOVE_HISTORY_OVERWRITE_EN makes it circular
module move_history
    import chess_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic          push_color_type,
    input  logic [63:0]   push_initialPosition,
    input  logic [63:0]   push_movedPosition,
    input  logic [5:0]    push_movingPiece,
    input  logic [5:0]    push_capturedPiece,
    input  logic [1:0]    push_castling,
    input  logic [4:0]    push_enpassant,
    input  logic          undo_req,
    output logic          undo_ack,
    output logic          undo_err,
    output logic          out_valid,
    output logic          out_undo,
    output logic          out_color_type,
    output logic [63:0]   out_initialPosition,
    output logic [63:0]   out_movedPosition,
    output logic [5:0]    out_movingPiece,
    output logic [5:0]    out_capturedPiece,
    output logic [1:0]    out_castling,
    output logic [4:0]    out_enpassant,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          bad_onehot
);

    hist_state_t r_state;
    logic [PW-1:0] r_top;
    logic [PW-1:0] r_base;
    logic          r_full;
    logic          r_bad_onehot;
    logic          r_undo_ack;
    logic          r_undo_err;
    logic          r_out_valid;
    logic          r_out_undo;
    logic          r_out_color;
    logic [63:0]   r_out_from;
    logic [63:0]   r_out_to;
    logic [5:0]    r_out_moving;
    logic [5:0]    r_out_captured;
    logic [1:0]    r_out_castling;
    logic [4:0]    r_out_ep;

    move_rec_t     r_mem [DEPTH];
    move_rec_t     r_rd_data;

    logic [5:0]    w_from_idx;
    logic [5:0]    w_to_idx;
    logic          w_from_ok;
    logic          w_to_ok;
    logic          w_room;
    logic          w_empty;
    logic          w_push_fire;
    logic          w_undo_take;
    logic          w_pop_start;
    logic [PW-1:0] w_top_inc;
    logic [PW-1:0] w_top_dec;
    move_rec_t     w_rec;

    onehot64_to_index u_from_idx (
        .i_vec          (push_initialPosition),
        .o_index        (w_from_idx),
        .o_valid_onehot (w_from_ok)
    );

    onehot64_to_index u_to_idx (
        .i_vec          (push_movedPosition),
        .o_index        (w_to_idx),
        .o_valid_onehot (w_to_ok)
    );

`ifdef MOVE_HISTORY_OVERWRITE_EN
    assign w_room = 1'b1;
`else
    assign w_room = !r_full;
`endif

    assign w_empty     = !r_full && (r_top == r_base);
    assign push_ready  = (r_state == ST_IDLE) && w_room;
    assign w_push_fire = push_valid && push_ready;
    // The ack cycle itself still sees the held request; it must not start a second pop.
    assign w_undo_take = undo_req && !r_undo_ack;
    assign w_pop_start = (r_state == ST_IDLE) && !w_push_fire && w_undo_take && !w_empty;
    assign w_top_inc   = r_top + PW'(1);
    assign w_top_dec   = r_top - PW'(1);

    always_comb begin
        w_rec           = '0;
        w_rec.from_idx  = w_from_idx;
        w_rec.to_idx    = w_to_idx;
        w_rec.moving    = push_movingPiece;
        w_rec.captured  = push_capturedPiece;
        w_rec.castling  = push_castling;
        w_rec.enpassant = push_enpassant;
        w_rec.color     = push_color_type;
    end

    always_ff @(posedge clk) begin
        if (w_push_fire) begin
            r_mem[r_top] <= w_rec;
        end
        if (w_pop_start) begin
            r_rd_data <= r_mem[w_top_dec];
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state        <= ST_IDLE;
            r_top          <= '0;
            r_base         <= '0;
            r_full         <= 1'b0;
            r_bad_onehot   <= 1'b0;
            r_undo_ack     <= 1'b0;
            r_undo_err     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_undo     <= 1'b0;
            r_out_color    <= 1'b0;
            r_out_from     <= '0;
            r_out_to       <= '0;
            r_out_moving   <= '0;
            r_out_captured <= '0;
            r_out_castling <= '0;
            r_out_ep       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_undo  <= 1'b0;
            r_undo_ack  <= 1'b0;
            r_undo_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_push_fire) begin
                        r_top <= w_top_inc;
                        // A push while full only happens in overwrite mode: drop the oldest.
                        if (r_full) begin
                            r_base <= r_base + PW'(1);
                        end else begin
                            r_full <= (w_top_inc == r_base);
                        end
                        if (!w_from_ok || !w_to_ok) begin
                            r_bad_onehot <= 1'b1;
                        end
                        r_out_valid    <= 1'b1;
                        r_out_color    <= push_color_type;
                        r_out_from     <= push_initialPosition;
                        r_out_to       <= push_movedPosition;
                        r_out_moving   <= push_movingPiece;
                        r_out_captured <= push_capturedPiece;
                        r_out_castling <= push_castling;
                        r_out_ep       <= push_enpassant;
                    end else if (w_undo_take) begin
                        if (w_empty) begin
                            r_undo_ack <= 1'b1;
                            r_undo_err <= 1'b1;
                        end else begin
                            r_top   <= w_top_dec;
                            r_full  <= 1'b0;
                            r_state <= ST_POP;
                        end
                    end
                end
                ST_POP: begin
                    r_out_valid    <= 1'b1;
                    r_out_undo     <= 1'b1;
                    r_undo_ack     <= 1'b1;
                    r_out_color    <= r_rd_data.color;
                    r_out_from     <= idx_to_onehot(r_rd_data.from_idx);
                    r_out_to       <= idx_to_onehot(r_rd_data.to_idx);
                    r_out_moving   <= r_rd_data.moving;
                    r_out_captured <= r_rd_data.captured;
                    r_out_castling <= r_rd_data.castling;
                    r_out_ep       <= r_rd_data.enpassant;
                    r_state        <= ST_EMIT;
                end
                ST_EMIT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign count               = r_full ? CW'(DEPTH) : {1'b0, r_top - r_base};
    assign empty               = w_empty;
    assign full                = r_full;
    assign bad_onehot          = r_bad_onehot;
    assign undo_ack            = r_undo_ack;
    assign undo_err            = r_undo_err;
    assign out_valid           = r_out_valid;
    assign out_undo            = r_out_undo;
    assign out_color_type      = r_out_color;
    assign out_initialPosition = r_out_from;
    assign out_movedPosition   = r_out_to;
    assign out_movingPiece     = r_out_moving;
    assign out_capturedPiece   = r_out_captured;
    assign out_castling        = r_out_castling;
    assign out_enpassant       = r_out_ep;

endmodule

// File: tb/tb_move_history.sv
// tb/tb_move_history.sv - randomized self-checking bench for move_history against a queue-based LIFO model
module tb_move_history;

    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef MOVE_HISTORY_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    typedef struct {
        logic       color;
        int         from;
        int         to;
        logic [5:0] mv;
        logic [5:0] cap;
        logic [1:0] cs;
        logic [4:0] ep;
    } mv_t;

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic          push_color_type = 1'b0;
    logic [63:0]   push_initialPosition = '0;
    logic [63:0]   push_movedPosition = '0;
    logic [5:0]    push_movingPiece = '0;
    logic [5:0]    push_capturedPiece = '0;
    logic [1:0]    push_castling = '0;
    logic [4:0]    push_enpassant = '0;
    logic          undo_req = 1'b0;
    logic          undo_ack, undo_err, out_valid, out_undo, out_color_type;
    logic [63:0]   out_initialPosition, out_movedPosition;
    logic [5:0]    out_movingPiece, out_capturedPiece;
    logic [1:0]    out_castling;
    logic [4:0]    out_enpassant;
    logic [CW-1:0] count;
    logic          empty, full, bad_onehot;
    logic [147:0]  w_out_bus;

    int  n_vec = 0;
    int  n_err = 0;
    mv_t stk[$];

    move_history #(.DEPTH(DEPTH)) dut (
        .clk(clk), .clear_n(clear_n),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_color_type(push_color_type),
        .push_initialPosition(push_initialPosition), .push_movedPosition(push_movedPosition),
        .push_movingPiece(push_movingPiece), .push_capturedPiece(push_capturedPiece),
        .push_castling(push_castling), .push_enpassant(push_enpassant),
        .undo_req(undo_req), .undo_ack(undo_ack), .undo_err(undo_err),
        .out_valid(out_valid), .out_undo(out_undo), .out_color_type(out_color_type),
        .out_initialPosition(out_initialPosition), .out_movedPosition(out_movedPosition),
        .out_movingPiece(out_movingPiece), .out_capturedPiece(out_capturedPiece),
        .out_castling(out_castling), .out_enpassant(out_enpassant),
        .count(count), .empty(empty), .full(full), .bad_onehot(bad_onehot)
    );

    assign w_out_bus = {out_color_type, out_initialPosition, out_movedPosition,
                        out_movingPiece, out_capturedPiece, out_castling, out_enpassant};

    always #5 clk = ~clk;

    function automatic logic [147:0] exp_bus(input mv_t m);
        logic [63:0] f, t;
        f = 64'd1 << m.from;
        t = 64'd1 << m.to;
        return {m.color, f, t, m.mv, m.cap, m.cs, m.ep};
    endfunction

    function automatic mv_t rand_move();
        mv_t m;
        m.color = 1'($urandom_range(0, 1));
        m.from  = int'($urandom_range(0, 63));
        m.to    = int'($urandom_range(0, 63));
        m.mv    = 6'd1 << $urandom_range(0, 5);
        m.cap   = ($urandom_range(0, 1) == 1) ? (6'd1 << $urandom_range(0, 5)) : 6'd0;
        m.cs    = 2'($urandom_range(0, 2));
        m.ep    = 5'($urandom_range(0, 31));
        return m;
    endfunction

    function automatic int lowest_bit(input logic [63:0] v);
        for (int i = 0; i < 64; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_move(input mv_t m);
        push_color_type      = m.color;
        push_initialPosition = 64'd1 << m.from;
        push_movedPosition   = 64'd1 << m.to;
        push_movingPiece     = m.mv;
        push_capturedPiece   = m.cap;
        push_castling        = m.cs;
        push_enpassant       = m.ep;
    endtask

    task automatic do_reset();
        push_valid = 1'b0;
        undo_req   = 1'b0;
        clear_n    = 1'b0;
        step();
        step();
        clear_n = 1'b1;
        stk.delete();
    endtask

    // Holds undo_req until undo_ack; lat = cycles to ack, -1 if it never came.
    task automatic run_undo(output int lat);
        undo_req = 1'b1;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (undo_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        undo_req = 1'b0;
    endtask

    task automatic model_push(input mv_t m);
        stk.push_back(m);
        if (stk.size() > DEPTH) void'(stk.pop_front());
    endtask

    task automatic test_reset();
        push_valid = 1'b0;
        undo_req   = 1'b0;
        clear_n    = 1'b0;
        step();
        n_vec++;
        if ({out_valid, out_undo, undo_ack, undo_err, empty, full, bad_onehot, push_ready} !== 8'b0000_1001) begin
            n_err++;
            $display("FAIL reset_flags got %b want %b",
                     {out_valid, out_undo, undo_ack, undo_err, empty, full, bad_onehot, push_ready}, 8'b0000_1001);
        end
        n_vec++;
        if (count !== '0) begin
            n_err++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        n_vec++;
        if (w_out_bus !== '0) begin
            n_err++;
            $display("FAIL reset_fields got %h want 0", w_out_bus);
        end
        clear_n = 1'b1;
        stk.delete();
    endtask

    task automatic test_forward();
        mv_t m;
        do_reset();
        m.color = 1'b1; m.from = 49; m.to = 56;
        m.mv = 6'b000001; m.cap = 6'b000010; m.cs = 2'b00; m.ep = 5'd0;
        drive_move(m);
        push_valid = 1'b1;
        step();
        push_valid = 1'b0;
        model_push(m);
        n_vec++;
        if ({out_valid, out_undo} !== 2'b10) begin
            n_err++;
            $display("FAIL fwd_valid got %b want 10", {out_valid, out_undo});
        end
        n_vec++;
        if (w_out_bus !== exp_bus(m)) begin
            n_err++;
            $display("FAIL fwd_fields got %h want %h", w_out_bus, exp_bus(m));
        end
        n_vec++;
        if ({count, bad_onehot, empty} !== {CW'(1), 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL fwd_status got %b want %b", {count, bad_onehot, empty}, {CW'(1), 1'b0, 1'b0});
        end
    endtask

    task automatic test_undo();
        int  lat;
        mv_t m;
        run_undo(lat);
        m = stk.pop_back();
        n_vec++;
        if (lat !== 2) begin
            n_err++;
            $display("FAIL undo_latency got %0d want 2", lat);
        end
        n_vec++;
        if ({out_valid, out_undo, undo_ack, undo_err} !== 4'b1110) begin
            n_err++;
            $display("FAIL undo_flags got %b want 1110", {out_valid, out_undo, undo_ack, undo_err});
        end
        n_vec++;
        if (w_out_bus !== exp_bus(m)) begin
            n_err++;
            $display("FAIL undo_fields got %h want %h", w_out_bus, exp_bus(m));
        end
        n_vec++;
        if ({count, empty} !== {CW'(0), 1'b1}) begin
            n_err++;
            $display("FAIL undo_status got %b want %b", {count, empty}, {CW'(0), 1'b1});
        end
        step();
        n_vec++;
        if ({out_valid, undo_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL undo_pulse got %b want 00", {out_valid, undo_ack});
        end
    endtask

    task automatic test_empty_undo();
        int lat;
        do_reset();
        run_undo(lat);
        n_vec++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL empty_undo_latency got %0d want 1", lat);
        end
        n_vec++;
        if ({undo_ack, undo_err, out_valid} !== 3'b110) begin
            n_err++;
            $display("FAIL empty_undo_flags got %b want 110", {undo_ack, undo_err, out_valid});
        end
        step();
        n_vec++;
        if ({undo_ack, out_valid, count} !== {2'b00, CW'(0)}) begin
            n_err++;
            $display("FAIL empty_undo_after got %b want %b", {undo_ack, out_valid, count}, {2'b00, CW'(0)});
        end
    endtask

    task automatic test_back_to_back();
        mv_t m;
        bit  acc;
        int  lat;
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            m = rand_move();
            drive_move(m);
            push_valid = 1'b1;
            acc = OVW || (stk.size() < DEPTH);
            n_vec++;
            if (push_ready !== acc) begin
                n_err++;
                $display("FAIL b2b_ready push %0d got %b want %b", i, push_ready, acc);
            end
            step();
            if (acc) model_push(m);
            n_vec++;
            if (out_valid !== acc) begin
                n_err++;
                $display("FAIL b2b_fwd push %0d got %b want %b", i, out_valid, acc);
            end
        end
        push_valid = 1'b0;
        n_vec++;
        if ({count, full} !== {CW'(DEPTH), 1'b1}) begin
            n_err++;
            $display("FAIL b2b_full got %b want %b", {count, full}, {CW'(DEPTH), 1'b1});
        end
        for (int i = 0; i < DEPTH; i++) begin
            run_undo(lat);
            m = stk.pop_back();
            n_vec++;
            if (lat !== 2 || w_out_bus !== exp_bus(m)) begin
                n_err++;
                $display("FAIL b2b_lifo pop %0d got lat %0d %h want lat 2 %h", i, lat, w_out_bus, exp_bus(m));
            end
            step();
        end
        n_vec++;
        if ({empty, full, count} !== {2'b10, CW'(0)}) begin
            n_err++;
            $display("FAIL b2b_drained got %b want %b", {empty, full, count}, {2'b10, CW'(0)});
        end
    endtask

    task automatic test_push_undo_same();
        mv_t m0, m1, m;
        int  lat;
        do_reset();
        m0 = rand_move();
        drive_move(m0);
        push_valid = 1'b1;
        step();
        model_push(m0);
        m1 = rand_move();
        drive_move(m1);
        undo_req = 1'b1;
        step();
        push_valid = 1'b0;
        model_push(m1);
        n_vec++;
        if ({out_valid, out_undo} !== 2'b10 || w_out_bus !== exp_bus(m1)) begin
            n_err++;
            $display("FAIL same_cycle_fwd got %b %h want 10 %h", {out_valid, out_undo}, w_out_bus, exp_bus(m1));
        end
        run_undo(lat);
        m = stk.pop_back();
        n_vec++;
        if (lat !== 2 || {out_valid, out_undo} !== 2'b11 || w_out_bus !== exp_bus(m)) begin
            n_err++;
            $display("FAIL same_cycle_undo got lat %0d %b %h want lat 2 11 %h",
                     lat, {out_valid, out_undo}, w_out_bus, exp_bus(m));
        end
        n_vec++;
        if (count !== CW'(stk.size())) begin
            n_err++;
            $display("FAIL same_cycle_count got %0d want %0d", count, stk.size());
        end
        step();
    endtask

    task automatic test_bad_onehot();
        mv_t         m;
        int          lat;
        logic [63:0] exp_to;
        do_reset();
        m = rand_move();
        drive_move(m);
        push_initialPosition = 64'h3;
        push_valid = 1'b1;
        step();
        push_valid = 1'b0;
        n_vec++;
        if (bad_onehot !== 1'b1) begin
            n_err++;
            $display("FAIL bad_onehot_set got %b want 1", bad_onehot);
        end
        step();
        step();
        n_vec++;
        if (bad_onehot !== 1'b1) begin
            n_err++;
            $display("FAIL bad_onehot_sticky got %b want 1", bad_onehot);
        end
        run_undo(lat);
        n_vec++;
        if (lat !== 2 || out_initialPosition !== 64'd1) begin
            n_err++;
            $display("FAIL bad_onehot_from got lat %0d %h want lat 2 %h", lat, out_initialPosition, 64'd1);
        end
        step();
        m = rand_move();
        drive_move(m);
        push_movedPosition = 64'h0000_0100_0000_0030;
        exp_to = 64'd1 << lowest_bit(push_movedPosition);
        push_valid = 1'b1;
        step();
        push_valid = 1'b0;
        run_undo(lat);
        n_vec++;
        if (lat !== 2 || out_movedPosition !== exp_to || bad_onehot !== 1'b1) begin
            n_err++;
            $display("FAIL bad_onehot_to got lat %0d %h bad %b want lat 2 %h bad 1",
                     lat, out_movedPosition, bad_onehot, exp_to);
        end
        step();
    endtask

    task automatic test_reset_abort();
        mv_t m;
        bit  seen;
        do_reset();
        m = rand_move();
        drive_move(m);
        push_valid = 1'b1;
        step();
        push_valid = 1'b0;
        undo_req = 1'b1;
        step();
        clear_n = 1'b0;
        #1;
        undo_req = 1'b0;
        n_vec++;
        if ({count, empty, out_valid, undo_ack} !== {CW'(0), 3'b100}) begin
            n_err++;
            $display("FAIL abort_in_reset got %b want %b", {count, empty, out_valid, undo_ack}, {CW'(0), 3'b100});
        end
        step();
        clear_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid === 1'b1 || undo_ack === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0 || empty !== 1'b1) begin
            n_err++;
            $display("FAIL abort_no_emit got emit %b empty %b want emit 0 empty 1", seen, empty);
        end
        stk.delete();
    endtask

    task automatic test_random();
        mv_t m;
        int  lat;
        bit  was_empty;
        do_reset();
        for (int op = 0; op < 300; op++) begin
            if ($urandom_range(0, 9) < 6 && (OVW || stk.size() < DEPTH)) begin
                m = rand_move();
                drive_move(m);
                push_valid = 1'b1;
                step();
                push_valid = 1'b0;
                model_push(m);
                n_vec++;
                if ({out_valid, out_undo} !== 2'b10 || w_out_bus !== exp_bus(m)) begin
                    n_err++;
                    $display("FAIL rand_fwd op %0d got %b %h want 10 %h",
                             op, {out_valid, out_undo}, w_out_bus, exp_bus(m));
                end
            end else begin
                was_empty = (stk.size() == 0);
                run_undo(lat);
                n_vec++;
                if (lat !== (was_empty ? 1 : 2) || {undo_ack, undo_err} !== {1'b1, was_empty}) begin
                    n_err++;
                    $display("FAIL rand_undo_ack op %0d got lat %0d ack/err %b want lat %0d ack/err %b",
                             op, lat, {undo_ack, undo_err}, (was_empty ? 1 : 2), {1'b1, was_empty});
                end
                if (!was_empty) begin
                    m = stk.pop_back();
                    n_vec++;
                    if ({out_valid, out_undo} !== 2'b11 || w_out_bus !== exp_bus(m)) begin
                        n_err++;
                        $display("FAIL rand_undo op %0d got %b %h want 11 %h",
                                 op, {out_valid, out_undo}, w_out_bus, exp_bus(m));
                    end
                end else begin
                    n_vec++;
                    if (out_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL rand_empty_emit op %0d got %b want 0", op, out_valid);
                    end
                end
                step();
            end
            n_vec++;
            if (count !== CW'(stk.size()) || empty !== (stk.size() == 0) || full !== (stk.size() == DEPTH)) begin
                n_err++;
                $display("FAIL rand_count op %0d got %0d e%b f%b want %0d", op, count, empty, full, stk.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_undo();
        test_empty_undo();
        test_back_to_back();
        test_push_undo_same();
        test_bad_onehot();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
